// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the two requesters.
// MEM_ARBITER_RR_EN: defined = round-robin on contention, undefined = port 0 fixed priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

`ifndef MEM_ARBITER_RR_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Single requester always wins; contention resolved by the selected policy.
  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    if (req == 2'b11) begin
`ifdef MEM_ARBITER_RR_EN
      grant = ~last_grant;
`else
      grant = PORT_CPU;
`endif
    end else if (req[1]) begin
      grant = PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port memory.
// One grant at a time: IDLE -> ACCESS (MEM_LAT cycles) -> ACK (1 cycle) -> IDLE.
// MEM_ARBITER_RR_EN selects round-robin arbitration (see mem_arb_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy,
  output logic              last_grant
);

  state_e             state_q, state_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q;
  logic [DATA_W-1:0]  rdata0_q, rdata1_q;
  logic               pick_valid, pick_grant;
  logic               load;
  logic               last_cycle;

  mem_arb_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  assign last_cycle = (state_q == StAccess) && (cnt_q == '0);

  // Next-state, latch enable and counter update.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StAccess;
          load    = 1'b1;
          cnt_d   = LAT_W'(MEM_LAT - 1);
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory strobes, acks and status decoded from the current state.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    if (state_q == StAccess) begin
      mem_read  = ~we_q;
      mem_write = we_q & last_cycle;
    end
    if (state_q == StAck) begin
      m0_ack = (last_grant_q == PORT_CPU);
      m1_ack = (last_grant_q == PORT_AUX);
    end
  end

  assign busy       = (state_q != StIdle);
  assign last_grant = last_grant_q;
  assign mem_addr   = addr_q;
  assign mem_datain = wdata_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, latency counter and per-port read data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_AUX;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        last_grant_q <= pick_grant;
        we_q         <= (pick_grant == PORT_AUX) ? m1_we    : m0_we;
        addr_q       <= (pick_grant == PORT_AUX) ? m1_addr  : m0_addr;
        wdata_q      <= (pick_grant == PORT_AUX) ? m1_wdata : m0_wdata;
      end
      if (last_cycle && !we_q) begin
        if (last_grant_q == PORT_AUX) begin
          rdata1_q <= mem_dataout;
        end else begin
          rdata0_q <= mem_dataout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// A transaction-level model predicts every output each cycle; directed tests add literal checks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [1:0]  ack   [2];
  logic [31:0] rdata [2][2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_datain [2];
  logic [31:0] mem_dataout [2];
  logic        mem_read [2];
  logic        mem_write [2];
  logic        busy [2];
  logic        last_grant [2];
  logic [31:0] env_mem [2][256];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: one outstanding transaction per instance, described by its start cycle.
  bit          act_m  [2];
  int          s_m    [2];
  bit          port_m [2];
  bit          we_m   [2];
  logic [31:0] addr_m [2];
  logic [31:0] wdata_m[2];
  logic [31:0] rd_m   [2][2];
  bit          lg_m   [2];
  logic [31:0] mem_m  [2][256];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT ((gi == 0) ? 1 : 3)
    ) u_dut (
      .CLK         (clk),
      .reset       (rst),
      .m0_req      (req[gi][0]),
      .m1_req      (req[gi][1]),
      .m0_we       (we[gi][0]),
      .m1_we       (we[gi][1]),
      .m0_addr     (addr[gi][0]),
      .m1_addr     (addr[gi][1]),
      .m0_wdata    (wdata[gi][0]),
      .m1_wdata    (wdata[gi][1]),
      .m0_ack      (ack[gi][0]),
      .m1_ack      (ack[gi][1]),
      .m0_rdata    (rdata[gi][0]),
      .m1_rdata    (rdata[gi][1]),
      .mem_addr    (mem_addr[gi]),
      .mem_read    (mem_read[gi]),
      .mem_write   (mem_write[gi]),
      .mem_datain  (mem_datain[gi]),
      .mem_dataout (mem_dataout[gi]),
      .busy        (busy[gi]),
      .last_grant  (last_grant[gi])
    );
    assign mem_dataout[gi] = env_mem[gi][mem_addr[gi][7:0]];
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Winner per the arbitration rules.
  function automatic bit pick(input logic [1:0] r, input bit lg);
    if (r == 2'b11) begin
`ifdef MEM_ARBITER_RR_EN
      return !lg;
`else
      return 1'b0;
`endif
    end
    return r[1] && !r[0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model and behavioural arbiter model, advanced at each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (mem_write[i] === 1'b1) env_mem[i][mem_addr[i][7:0]] = mem_datain[i];
      if (rst) begin
        act_m[i]   = 1'b0;
        addr_m[i]  = '0;
        wdata_m[i] = '0;
        rd_m[i][0] = '0;
        rd_m[i][1] = '0;
        lg_m[i]    = 1'b1;
      end else if (act_m[i]) begin
        if (cyc == s_m[i] + lat(i)) begin
          if (we_m[i]) mem_m[i][addr_m[i][7:0]] = wdata_m[i];
          else rd_m[i][port_m[i]] = mem_m[i][addr_m[i][7:0]];
        end
        if (cyc == s_m[i] + lat(i) + 1) act_m[i] = 1'b0;
      end else if (req[i] != 2'b00) begin
        port_m[i]  = pick(req[i], lg_m[i]);
        lg_m[i]    = port_m[i];
        act_m[i]   = 1'b1;
        s_m[i]     = cyc;
        we_m[i]    = we[i][port_m[i]];
        addr_m[i]  = addr[i][port_m[i]];
        wdata_m[i] = wdata[i][port_m[i]];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        bit in_acc, in_ack;
        in_acc = act_m[i] && (cyc >= s_m[i]) && (cyc < s_m[i] + lat(i));
        in_ack = act_m[i] && (cyc == s_m[i] + lat(i));
        chk($sformatf("u%0d busy", i), busy[i], in_acc || in_ack);
        chk($sformatf("u%0d mem_read", i), mem_read[i], in_acc && !we_m[i]);
        chk($sformatf("u%0d mem_write", i), mem_write[i],
            in_acc && we_m[i] && (cyc == s_m[i] + lat(i) - 1));
        chk($sformatf("u%0d m0_ack", i), ack[i][0], in_ack && (port_m[i] == 1'b0));
        chk($sformatf("u%0d m1_ack", i), ack[i][1], in_ack && (port_m[i] == 1'b1));
        chk($sformatf("u%0d mem_addr", i), mem_addr[i], addr_m[i]);
        chk($sformatf("u%0d mem_datain", i), mem_datain[i], wdata_m[i]);
        chk($sformatf("u%0d m0_rdata", i), rdata[i][0], rd_m[i][0]);
        chk($sformatf("u%0d m1_rdata", i), rdata[i][1], rd_m[i][1]);
        chk($sformatf("u%0d last_grant", i), last_grant[i], lg_m[i]);
      end
    end
  end

  // One request on one port; reports ack latency (cycles after the request cycle) and strobe counts.
  task automatic do_access(input int i, input int p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output int ack_dly, output int rd_n,
                           output int wr_n, output int wr_dly, output int oth);
    int n0;
    n0 = cyc;
    we[i][p] = w;
    addr[i][p] = a;
    wdata[i][p] = d;
    req[i][p] = 1'b1;
    ack_dly = -1;
    rd_n = 0;
    wr_n = 0;
    wr_dly = -1;
    oth = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_read[i]) rd_n++;
      if (mem_write[i]) begin
        wr_n++;
        wr_dly = cyc - n0;
      end
      if (ack[i][1-p]) oth++;
      if (ack[i][p]) begin
        ack_dly = cyc - n0;
        break;
      end
    end
    tick();
    req[i][p] = 1'b0;
  endtask

  initial begin
    int ad, rn, wn, wd, ot, n, cnt;
    int ord [4];
    int lgs [4];
    int exp_ord [4];
`ifdef MEM_ARBITER_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) begin
        env_mem[i][a] = (32'(a) * 32'h0101_0101) ^ 32'h5A5A_0000;
        mem_m[i][a]   = (32'(a) * 32'h0101_0101) ^ 32'h5A5A_0000;
      end
      env_mem[i][8'h10] = 32'hDEAD_BEEF;
      mem_m[i][8'h10]   = 32'hDEAD_BEEF;
      req[i] = 2'b00;
      we[i]  = 2'b00;
      for (int p = 0; p < 2; p++) begin
        addr[i][p]  = '0;
        wdata[i][p] = '0;
      end
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("reset busy", busy[0], 0);
    chk("reset last_grant", last_grant[1], 1);
    chk("reset m0_rdata", rdata[0][0], 0);
    chk("reset mem_addr", mem_addr[1], 0);
    tick();

    // Single read, MEM_LAT=1.
    do_access(0, 0, 1'b0, 32'h10, 32'h0, ad, rn, wn, wd, ot);
    chk("read ack latency", ad, 2);
    chk("read mem_read cycles", rn, 1);
    chk("read mem_write cycles", wn, 0);
    chk("read m1_ack count", ot, 0);
    chk("read m0_rdata", rdata[0][0], 32'hDEAD_BEEF);

    // Write with MEM_LAT=3, then read it back.
    do_access(1, 1, 1'b1, 32'h20, 32'h1234, ad, rn, wn, wd, ot);
    chk("write ack latency", ad, 4);
    chk("write mem_read cycles", rn, 0);
    chk("write pulse count", wn, 1);
    chk("write pulse cycle", wd, 3);
    do_access(1, 1, 1'b0, 32'h20, 32'h0, ad, rn, wn, wd, ot);
    chk("readback ack latency", ad, 4);
    chk("readback m1_rdata", rdata[1][1], 32'h1234);

    // Contention on both ports from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr[0][0] = 32'h10;
    addr[0][1] = 32'h11;
    we[0] = 2'b00;
    req[0] = 2'b11;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (ack[0][0] || ack[0][1]) begin
        ord[n] = ack[0][1] ? 1 : 0;
        lgs[n] = int'(last_grant[0]);
        n++;
      end
    end
    tick();
    req[0] = 2'b00;
    chk("contention ack count", n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        chk($sformatf("contention grant %0d", k), ord[k], exp_ord[k]);
        chk($sformatf("contention last_grant %0d", k), lgs[k], exp_ord[k]);
      end
    end
    repeat (2) tick();

    // Reset in the 2nd ACCESS cycle of a MEM_LAT=3 read.
    addr[1][1] = 32'h20;
    we[1] = 2'b00;
    req[1][1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    req[1][1] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset busy", busy[1], 0);
    chk("midreset mem_read", mem_read[1], 0);
    chk("midreset mem_write", mem_write[1], 0);
    chk("midreset acks", ack[1], 2'b00);
    chk("midreset m0_rdata", rdata[1][0], 0);
    chk("midreset m1_rdata", rdata[1][1], 0);
    tick();
    do_access(1, 1, 1'b0, 32'h20, 32'h0, ad, rn, wn, wd, ot);
    chk("post-reset ack latency", ad, 4);
    chk("post-reset m1_rdata", rdata[1][1], 32'h1234);

    // Request dropped right after the grant edge.
    addr[1][0] = 32'h10;
    we[1][0] = 1'b0;
    req[1][0] = 1'b1;
    tick();
    req[1][0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack[1][0]) cnt++;
    end
    chk("dropped req ack count", cnt, 1);
    chk("dropped req busy", busy[1], 0);
    chk("dropped req m0_rdata", rdata[1][0], 32'hDEAD_BEEF);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port `memory` block. It shares one memory between the `cpucore` instance (port 0) and a second requester (port 1), such as a debug or display scanner or a program loader. It grants one requester at a time and drives the `memory` strobes for a fixed number of cycles. Each granted access completes with a one-cycle acknowledge.

## Interface
- `ADDR_W`, 32, address width, passed through unchanged
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles the memory strobe is held per access; legal range 1..15

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req`, `m1_req`  in  1  access request; held high until the matching ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req is high
- `m0_addr`, `m1_addr`  in  ADDR_W  access address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  DATA_W  registered read data; holds the port's last completed read
- `mem_addr`  out  ADDR_W  address to `memory`
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_datain`  out  DATA_W  write data to `memory`
- `mem_dataout`  in  DATA_W  read data from `memory`
- `busy`  out  1  high whenever the state is not IDLE
- `last_grant`  out  1  index of the most recently granted port

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any request is high, pick a winner, latch its we/addr/wdata and the grant index, load the lat counter with MEM_LAT-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - `mem_addr` and `mem_datain` are driven from the latched values.
  - `mem_read` = !we on every ACCESS cycle.
  - `mem_write` = we only on the final ACCESS cycle, when the counter is 0, giving a single write pulse.
  - The counter decrements each cycle. On the edge where it is 0, a read captures `mem_dataout` into the granted port's rdata, and the FSM goes to ACK.
- ACK:
  - The granted port's ack is high for exactly this cycle. Both strobes are low.
  - Next state is always IDLE. There is no back-to-back grant from ACK.
- Requester rules:
  - A requester may drop req after seeing ack. If it keeps req high, that is a new request, arbitrated in the following IDLE cycle.
  - Dropping req during ACCESS does not abort the access; the access completes and ack still pulses.
  - Changes to we, addr or wdata after the grant are ignored.
- Outputs while idle: `mem_addr` and `mem_datain` hold their last latched values. Strobes are 0.
- Writes do not modify rdata.

## Timing
- If req is sampled high in IDLE at edge k, then ACCESS covers cycles k+1 .. k+MEM_LAT and ack is high in cycle k+MEM_LAT+1.
- Throughput is one access per MEM_LAT+2 cycles.
- Read data is valid on rdata in the ack cycle and stays there until that port's next completed read.
- Reset values:
  - state = IDLE
  - all acks, `mem_read`, `mem_write` and `busy` = 0
  - `mem_addr`, `mem_datain`, `m0_rdata`, `m1_rdata` = 0
  - `last_grant` = 1, so port 0 wins the first contention
- Reset during ACCESS or ACK: the next cycle is IDLE with strobes low and no ack. The interrupted access is lost and must be re-requested.
- Both requests high in IDLE: resolved by the arbitration policy in Configuration.
- No request in IDLE: no state change and `last_grant` is unchanged.

## Configuration
- `MEM_ARBITER_RR_EN`
  - Defined: round-robin. On contention, grant the port that is not `last_grant`. A single requester is always granted.
  - Undefined: fixed priority. Port 0 always wins contention, and port 1 can be starved.
- `last_grant` updates on every grant in both modes.

## Structure
- Package `mem_arbiter_pkg`:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2)
  - port index constants PORT_CPU=1'b0, PORT_AUX=1'b1
  - counter width LAT_W=4
- One sub-module, `mem_arb_pick`: combinational winner selection from req[1:0] and last_grant, with the policy selected by the macro.
- The FSM, latches, counter and rdata registers live in the top module.

## Test plan
- Single read: MEM_LAT=1, memory word 0x10 = 0xDEADBEEF. Raise `m0_req` with we=0, addr=0x10 → `mem_read` high for 1 cycle, `m0_ack` high 2 cycles after the request edge, `m0_rdata` = 0xDEADBEEF; `m1_ack` stays 0.
- Write with latency: MEM_LAT=3, `m1` writes 0x1234 to 0x20 → `mem_read` stays 0, `mem_write` pulses exactly once (3rd ACCESS cycle), `m1_ack` at k+4; reading 0x20 afterwards returns 0x1234.
- Contention under fixed priority (macro undefined): both reqs held high for 4 accesses → all 4 acks go to port 0, `m1_ack` never asserts.
- Contention under round-robin (`MEM_ARBITER_RR_EN` defined): both reqs held high for 4 accesses → grants alternate 0,1,0,1 and `last_grant` toggles each access.
- Reset mid-access: MEM_LAT=3, assert reset in the 2nd ACCESS cycle → next cycle `busy`=0, strobes 0, no ack, both rdata = 0; a fresh request completes normally.
- Req dropped during ACCESS: `m0_req` goes low after the grant edge → access still completes, `m0_ack` pulses once, FSM returns to IDLE and stays there.
